// File: rtl/ysyx_22040895_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_22040895_lsu : load/store unit with memory handshake, alignment and
//                     timeout faults. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ysyx_22040895_lsu #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] result_i,
  input  logic [63:0] mdata_i,
  input  logic [1:0]  memop_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [4:0]  rd_i,
  input  logic        wen_i,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] wdata_o,
  output logic [4:0]  rd_o,
  output logic        wen_o,
  output logic        exc_o,
  output logic [3:0]  exc_cause_o
);

  localparam int              CNT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_limit   = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [1:0]      c_st_idle  = 2'd0;
  localparam logic [1:0]      c_st_req   = 2'd1;
  localparam logic [1:0]      c_st_wait  = 2'd2;
  localparam logic [1:0]      c_st_resp  = 2'd3;

  logic [1:0]       r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_addr, r_st_data, r_wdata;
  logic [7:0]       r_st_mask;
  logic [1:0]       r_size;
  logic             r_is_store, r_unsigned, r_wen, r_exc;
  logic [4:0]       r_rd;
  logic [3:0]       r_cause;

  logic        w_is_load, w_is_store, w_misalign, w_done, w_tmo, w_busy;
  logic [7:0]  w_mask_base;
  logic [63:0] w_rsh, w_ldata;

  assign w_is_load  = (memop_i == 2'b01);
  assign w_is_store = (memop_i == 2'b10);
  assign w_busy     = (r_state == c_st_req) || (r_state == c_st_wait);

  always_comb begin
    w_misalign  = 1'b0;
    w_mask_base = 8'h01;
    case (size_i)
      2'b00: begin w_misalign = 1'b0;              w_mask_base = 8'h01; end
      2'b01: begin w_misalign = result_i[0];       w_mask_base = 8'h03; end
      2'b10: begin w_misalign = |result_i[1:0];    w_mask_base = 8'h0F; end
      default: begin w_misalign = |result_i[2:0];  w_mask_base = 8'hFF; end
    endcase
  end

  // A grant completes a store; a load completes on read data, which may
  // coincide with its grant.
  assign w_done = ((r_state == c_st_req) && mem_gnt && (r_is_store || mem_rvalid)) ||
                  ((r_state == c_st_wait) && mem_rvalid);
  assign w_tmo  = w_busy && (r_cnt >= c_limit) && !w_done;

  assign w_rsh = mem_rdata >> {r_addr[2:0], 3'b000};

  always_comb begin
    w_ldata = w_rsh;
    case (r_size)
      2'b00:   w_ldata = r_unsigned ? {56'd0, w_rsh[7:0]}  : {{56{w_rsh[7]}},  w_rsh[7:0]};
      2'b01:   w_ldata = r_unsigned ? {48'd0, w_rsh[15:0]} : {{48{w_rsh[15]}}, w_rsh[15:0]};
      2'b10:   w_ldata = r_unsigned ? {32'd0, w_rsh[31:0]} : {{32{w_rsh[31]}}, w_rsh[31:0]};
      default: w_ldata = w_rsh;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_st_idle;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (in_valid) begin
          if ((w_is_load || w_is_store) && !w_misalign) w_next = c_st_req;
          else                                          w_next = c_st_resp;
        end
      end
      c_st_req: begin
        if (w_done || w_tmo) w_next = c_st_resp;
        else if (mem_gnt)    w_next = c_st_wait;
      end
      c_st_wait: begin
        if (w_done || w_tmo) w_next = c_st_resp;
      end
      default: begin
        if (out_ready) w_next = c_st_idle;
      end
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_st_idle);
    mem_req   = (r_state == c_st_req);
    mem_we    = 1'b0;
    mem_addr  = 64'd0;
    mem_wdata = 64'd0;
    mem_wmask = 8'd0;
    out_valid = (r_state == c_st_resp);
    if (r_state == c_st_req) begin
      mem_we    = r_is_store;
      mem_addr  = {r_addr[63:3], 3'b000};
      mem_wdata = r_st_data;
      mem_wmask = r_st_mask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_addr     <= 64'd0;
      r_st_data  <= 64'd0;
      r_st_mask  <= 8'd0;
      r_size     <= 2'd0;
      r_is_store <= 1'b0;
      r_unsigned <= 1'b0;
      r_rd       <= 5'd0;
      r_wdata    <= 64'd0;
      r_wen      <= 1'b0;
      r_exc      <= 1'b0;
      r_cause    <= 4'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_addr     <= result_i;
            r_is_store <= w_is_store;
            r_size     <= size_i;
            r_unsigned <= unsigned_i;
            r_rd       <= rd_i;
            r_st_data  <= mdata_i << {result_i[2:0], 3'b000};
            r_st_mask  <= w_mask_base << result_i[2:0];
            r_cnt      <= '0;
            if (!(w_is_load || w_is_store)) begin
              r_wdata <= result_i;
              r_wen   <= wen_i;
              r_exc   <= 1'b0;
              r_cause <= 4'd0;
            end else if (w_misalign) begin
              r_wdata <= 64'd0;
              r_wen   <= 1'b0;
              r_exc   <= 1'b1;
              r_cause <= w_is_store ? 4'd6 : 4'd4;
            end else begin
              r_wdata <= 64'd0;
              r_wen   <= wen_i && w_is_load;
              r_exc   <= 1'b0;
              r_cause <= 4'd0;
            end
          end
        end
        c_st_req, c_st_wait: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_done && !r_is_store) r_wdata <= w_ldata;
          if (w_tmo) begin
            r_exc   <= 1'b1;
            r_wen   <= 1'b0;
            r_cause <= r_is_store ? 4'd7 : 4'd5;
          end
        end
        default: ;
      endcase
    end
  end

  assign wdata_o     = r_wdata;
  assign rd_o        = r_rd;
  assign wen_o       = r_wen;
  assign exc_o       = r_exc;
  assign exc_cause_o = r_cause;

endmodule

`default_nettype wire

// File: doc/ysyx_22040895_lsu.md
YSYX_22040895_LSU -- requirements
Module: ysyx_22040895_lsu

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum cycles spent in REQ+WAIT before an access fault is raised.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  execute stage presents an instruction.
REQ-005 in_ready  output  1  LSU can accept an instruction.
REQ-006 result_i  input  64  execute result; this is the effective address for memory ops.
REQ-007 mdata_i  input  64  store data.
REQ-008 memop_i  input  2  operation: 00 none, 01 load, 10 store, 11 treated as none.
REQ-009 size_i  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-010 unsigned_i  input  1  zero-extend the load result when 1.
REQ-011 rd_i / wen_i  input  5 / 1  destination register and write enable, passed through.
REQ-012 mem_req / mem_we  output  1 / 1  memory request and write strobe.
REQ-013 mem_addr  output  64  8-byte-aligned address: result_i with bits [2:0] cleared.
REQ-014 mem_wdata / mem_wmask  output  64 / 8  lane-positioned store data and byte mask.
REQ-015 mem_gnt / mem_rvalid / mem_rdata  input  1 / 1 / 64  grant, read-data valid, read data.
REQ-016 out_valid / out_ready  output / input  1 / 1  handshake to the writeback stage.
REQ-017 wdata_o / rd_o / wen_o  output  64 / 5 / 1  writeback data, register and enable.
REQ-018 exc_o / exc_cause_o  output  1 / 4  exception flag and cause code.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, RESP; in_ready = 1 only in IDLE.
REQ-020 IDLE: on in_valid && in_ready, capture all inputs; none-op -> RESP with wdata_o = result_i (latency 1 cycle); load/store -> REQ.
REQ-021 Misalignment: half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0. A misaligned access goes IDLE -> RESP, never asserts mem_req, and sets exc_o=1 with cause 4 (load) or 6 (store), wen_o=0.
REQ-022 REQ: mem_req=1, with mem_addr, mem_we, mem_wdata and mem_wmask held stable until mem_gnt; on mem_gnt, a store goes to RESP and a load goes to WAIT.
REQ-023 WAIT: on mem_rvalid, capture the extracted load data and go to RESP; mem_req=0.
REQ-024 Load extract: shift mem_rdata right by addr[2:0]*8, take the low 8/16/32/64 bits, then sign- or zero-extend to 64 per unsigned_i.
REQ-025 Store: shift mdata_i left by addr[2:0]*8; mask = (1/3/F/FF) << addr[2:0].
REQ-026 Timeout counter: clears on entering REQ and increments each cycle in REQ or WAIT. When it reaches MEM_TIMEOUT, go to RESP with exc_o=1, cause 5 (load) or 7 (store), wen_o=0, and mem_req deasserted.
REQ-027 RESP: out_valid=1 with all outputs stable until out_ready; on out_ready go to IDLE. No new instruction is accepted in the same cycle.
REQ-028 Stores have wen_o=0 regardless of wen_i.
REQ-029 mem_gnt and mem_rvalid arriving together in REQ for a load: capture rdata and go directly to RESP.
REQ-030 mem_rvalid outside WAIT, and mem_gnt outside REQ, are ignored.

Reset
REQ-031 While rst=0: FSM=IDLE, counter=0, mem_req=0, mem_we=0, out_valid=0, exc_o=0, and all data outputs = 0, asynchronously.
REQ-032 Reset asserted mid-REQ or mid-WAIT drops mem_req immediately; the outstanding access is abandoned and a late mem_rvalid after reset is ignored.

Verification
REQ-033 Load byte signed: addr 0x80000003, rdata 0x00000000_80000000 => 0x..FF80 byte at lane 3 -> wdata_o=0xFFFFFFFFFFFFFF80, wen_o=1.
REQ-034 Store half: addr 0x80000006, mdata 0xABCD -> mem_wdata=0xABCD0000_00000000, mem_wmask=0xC0, mem_we=1, then RESP with wen_o=0.
REQ-035 Misaligned word load at addr 0x80000002 -> no mem_req, out_valid the next cycle, exc_o=1, cause=4.
REQ-036 Gnt withheld for MEM_TIMEOUT=4 cycles on a store -> exc_o=1, cause=7, mem_req low after timeout.
REQ-037 out_ready held low for 3 cycles in RESP -> outputs stable, in_ready=0, then IDLE the cycle after out_ready.
REQ-038 Reset pulsed in WAIT, followed by mem_rvalid -> state IDLE, out_valid=0, no writeback produced.
